// File: rtl/needs_engine.sv
// Pet need-level generator: advances the six needs on a prescaled game tick,
// applies accepted care actions and tracks the ALIVE/SLEEPING/DEAD life state.
module needs_engine #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int HUNGER_PER  = 2,
    parameter int HAPPY_PER   = 3,
    parameter int HYGIENE_PER = 4,
    parameter int ENERGY_PER  = 5,
    parameter int SOCIAL_PER  = 3,
    parameter int HEAL_PER    = 4,
    parameter int SLEEP_TICKS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        act_valid,
    input  logic [2:0]  act_code,
    output logic        act_ready,
    output logic [3:0]  hunger,
    output logic [4:0]  happiness,
    output logic [3:0]  health,
    output logic [3:0]  hygiene,
    output logic [3:0]  energy,
    output logic [3:0]  social,
    output logic        sleeping,
    output logic        dead,
    output logic [15:0] age
);

    localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] ACT_FEED     = 3'd0;
    localparam logic [2:0] ACT_PLAY     = 3'd1;
    localparam logic [2:0] ACT_CLEAN    = 3'd2;
    localparam logic [2:0] ACT_SLEEP    = 3'd3;
    localparam logic [2:0] ACT_MEDICINE = 3'd4;
    localparam logic [2:0] ACT_SOCIAL   = 3'd5;

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        SLEEPING = 2'd1,
        DEAD     = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [PSW-1:0] presc;
    logic           tick, accept, afflicted;
    logic [7:0]     hun_cnt, hap_cnt, hyg_cnt, eng_cnt, soc_cnt, heal_cnt, slp_cnt;
    logic [7:0]     hun_cnt_nx, hap_cnt_nx, hyg_cnt_nx, eng_cnt_nx, soc_cnt_nx, heal_cnt_nx, slp_cnt_nx;
    logic [3:0]     hunger_nx, health_nx, hygiene_nx, energy_nx, social_nx;
    logic [4:0]     happiness_nx;
    logic [15:0]    age_nx;

    function automatic logic [3:0] add4(input logic [3:0] v, input logic [3:0] n);
        logic [4:0] s;
        s = {1'b0, v} + {1'b0, n};
        return (s > 5'd15) ? 4'd15 : s[3:0];
    endfunction

    function automatic logic [3:0] sub4(input logic [3:0] v, input logic [3:0] n);
        return (v >= n) ? v - n : 4'd0;
    endfunction

    function automatic logic [4:0] add5(input logic [4:0] v, input logic [4:0] n);
        logic [5:0] s;
        s = {1'b0, v} + {1'b0, n};
        return (s > 6'd31) ? 5'd31 : s[4:0];
    endfunction

    function automatic logic [4:0] sub5(input logic [4:0] v, input logic [4:0] n);
        return (v >= n) ? v - n : 5'd0;
    endfunction

    function automatic logic fires(input logic [7:0] c, input int per);
        return c == 8'(per - 1);
    endfunction

    assign tick      = (presc == PSW'(TICK_DIV - 1));
    assign act_ready = (state == ALIVE) && !reset;
    assign accept    = act_valid && act_ready;

    // The action is applied first; the tick then works on the post-action values.
    always_comb begin
        state_nx     = state;
        hunger_nx    = hunger;
        happiness_nx = happiness;
        health_nx    = health;
        hygiene_nx   = hygiene;
        energy_nx    = energy;
        social_nx    = social;
        age_nx       = age;
        hun_cnt_nx   = hun_cnt;
        hap_cnt_nx   = hap_cnt;
        hyg_cnt_nx   = hyg_cnt;
        eng_cnt_nx   = eng_cnt;
        soc_cnt_nx   = soc_cnt;
        heal_cnt_nx  = heal_cnt;
        slp_cnt_nx   = slp_cnt;
        afflicted    = 1'b0;

        if (state != DEAD) begin
            if (accept) begin
                case (act_code)
                    ACT_FEED:     hunger_nx = sub4(hunger, 4'd4);
                    ACT_PLAY: begin
                        happiness_nx = sub5(happiness, 5'd4);
                        energy_nx    = add4(energy, 4'd2);
                    end
                    ACT_CLEAN:    hygiene_nx = 4'd0;
                    ACT_SLEEP: begin
                        state_nx   = SLEEPING;
                        slp_cnt_nx = 8'd0;
                    end
                    ACT_MEDICINE: health_nx = sub4(health, 4'd6);
                    ACT_SOCIAL: begin
                        social_nx    = sub4(social, 4'd4);
                        happiness_nx = sub5(happiness, 5'd2);
                    end
                    default: ;
                endcase
            end

            if (tick) begin
                age_nx = (age == 16'hFFFF) ? age : age + 16'd1;

                // Affliction is judged before this tick's own hunger/hygiene growth.
                afflicted = (hunger_nx >= 4'd12) || (hygiene_nx >= 4'd12);
                if (afflicted) begin
                    health_nx   = add4(health_nx, 4'd1);
                    heal_cnt_nx = 8'd0;
                end else if (fires(heal_cnt, HEAL_PER)) begin
                    health_nx   = sub4(health_nx, 4'd1);
                    heal_cnt_nx = 8'd0;
                end else begin
                    heal_cnt_nx = heal_cnt + 8'd1;
                end

                if (fires(hun_cnt, HUNGER_PER)) begin
                    hunger_nx  = add4(hunger_nx, 4'd1);
                    hun_cnt_nx = 8'd0;
                end else begin
                    hun_cnt_nx = hun_cnt + 8'd1;
                end

                if (state == ALIVE) begin
                    if (fires(hap_cnt, HAPPY_PER)) begin
                        happiness_nx = add5(happiness_nx, 5'd1);
                        hap_cnt_nx   = 8'd0;
                    end else begin
                        hap_cnt_nx = hap_cnt + 8'd1;
                    end
                    if (fires(hyg_cnt, HYGIENE_PER)) begin
                        hygiene_nx = add4(hygiene_nx, 4'd1);
                        hyg_cnt_nx = 8'd0;
                    end else begin
                        hyg_cnt_nx = hyg_cnt + 8'd1;
                    end
                    if (fires(soc_cnt, SOCIAL_PER)) begin
                        social_nx  = add4(social_nx, 4'd1);
                        soc_cnt_nx = 8'd0;
                    end else begin
                        soc_cnt_nx = soc_cnt + 8'd1;
                    end
                    if (fires(eng_cnt, ENERGY_PER)) begin
                        energy_nx  = add4(energy_nx, 4'd1);
                        eng_cnt_nx = 8'd0;
                    end else begin
                        eng_cnt_nx = eng_cnt + 8'd1;
                    end
                end else begin
                    energy_nx  = sub4(energy_nx, 4'd1);
                    slp_cnt_nx = slp_cnt + 8'd1;
                    if ((energy_nx == 4'd0) || (slp_cnt_nx == 8'(SLEEP_TICKS))) begin
                        state_nx   = ALIVE;
                        eng_cnt_nx = 8'd0;
                    end
                end
            end

            if ((hunger_nx == 4'd15) || (health_nx == 4'd15)) begin
                state_nx = DEAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ALIVE;
            presc     <= '0;
            hun_cnt   <= 8'd0;
            hap_cnt   <= 8'd0;
            hyg_cnt   <= 8'd0;
            eng_cnt   <= 8'd0;
            soc_cnt   <= 8'd0;
            heal_cnt  <= 8'd0;
            slp_cnt   <= 8'd0;
            hunger    <= 4'd0;
            happiness <= 5'd0;
            health    <= 4'd0;
            hygiene   <= 4'd0;
            energy    <= 4'd0;
            social    <= 4'd0;
            age       <= 16'd0;
            sleeping  <= 1'b0;
            dead      <= 1'b0;
        end else begin
            state     <= state_nx;
            presc     <= tick ? '0 : presc + PSW'(1);
            hun_cnt   <= hun_cnt_nx;
            hap_cnt   <= hap_cnt_nx;
            hyg_cnt   <= hyg_cnt_nx;
            eng_cnt   <= eng_cnt_nx;
            soc_cnt   <= soc_cnt_nx;
            heal_cnt  <= heal_cnt_nx;
            slp_cnt   <= slp_cnt_nx;
            hunger    <= hunger_nx;
            happiness <= happiness_nx;
            health    <= health_nx;
            hygiene   <= hygiene_nx;
            energy    <= energy_nx;
            social    <= social_nx;
            age       <= age_nx;
            sleeping  <= (state_nx == SLEEPING);
            dead      <= (state_nx == DEAD);
        end
    end

endmodule

// File: tb/tb_needs_engine.sv
// Self-checking bench for needs_engine: action table, hand-written corner
// sequences and randomized episodes against a tick-count based reference model.
module tb_needs_engine;

    localparam int TD    = 4;
    localparam int HUNP  = 2;
    localparam int HAPP  = 3;
    localparam int HYGP  = 4;
    localparam int ENGP  = 5;
    localparam int SOCP  = 3;
    localparam int HEALP = 4;
    localparam int SLPT  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        act_valid;
    logic [2:0]  act_code;
    logic        act_ready;
    logic [3:0]  hunger;
    logic [4:0]  happiness;
    logic [3:0]  health;
    logic [3:0]  hygiene;
    logic [3:0]  energy;
    logic [3:0]  social;
    logic        sleeping;
    logic        dead;
    logic [15:0] age;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_no      = 0;

    needs_engine #(
        .TICK_DIV(TD), .HUNGER_PER(HUNP), .HAPPY_PER(HAPP), .HYGIENE_PER(HYGP),
        .ENERGY_PER(ENGP), .SOCIAL_PER(SOCP), .HEAL_PER(HEALP), .SLEEP_TICKS(SLPT)
    ) dut (
        .clk(clk), .reset(reset), .act_valid(act_valid), .act_code(act_code),
        .act_ready(act_ready), .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social), .sleeping(sleeping),
        .dead(dead), .age(age)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        int hunger, happiness, health, hygiene, energy, social, sleeping, ready;
    } vec_t;

    vec_t vecs[8];

    // Reference model state: plain integers and running tick counts.
    int m_hunger, m_happy, m_health, m_hygiene, m_energy, m_social, m_age;
    int m_cyc, m_live, m_awake, m_eticks, m_heal_run, m_sticks;
    bit m_sleep, m_dead;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [63:0] expPack(input int h, input int hap, input int hl, input int hy,
                                            input int e, input int s, input int sl, input int d,
                                            input int r, input int ag);
        return {20'd0, 4'(h), 5'(hap), 4'(hl), 4'(hy), 4'(e), 4'(s), 1'(sl), 1'(d), 1'(r), 16'(ag)};
    endfunction

    function automatic logic [63:0] dutPack();
        return {20'd0, hunger, happiness, health, hygiene, energy, social, sleeping, dead, act_ready, age};
    endfunction

    function automatic void modelReset();
        m_hunger = 0; m_happy = 0; m_health = 0; m_hygiene = 0; m_energy = 0; m_social = 0;
        m_age = 0; m_cyc = 0; m_live = 0; m_awake = 0; m_eticks = 0; m_heal_run = 0;
        m_sticks = 0; m_sleep = 0; m_dead = 0;
    endfunction

    function automatic void modelStep(input bit v, input int c);
        bit is_tick, was_sleep;
        is_tick = ((m_cyc + 1) % TD) == 0;
        m_cyc++;
        if (m_dead) return;
        was_sleep = m_sleep;
        if (v && !m_sleep) begin
            case (c)
                0: m_hunger = clampi(m_hunger - 4, 0, 15);
                1: begin m_happy = clampi(m_happy - 4, 0, 31); m_energy = clampi(m_energy + 2, 0, 15); end
                2: m_hygiene = 0;
                3: begin m_sleep = 1; m_sticks = 0; end
                4: m_health = clampi(m_health - 6, 0, 15);
                5: begin m_social = clampi(m_social - 4, 0, 15); m_happy = clampi(m_happy - 2, 0, 31); end
                default: ;
            endcase
        end
        if (is_tick) begin
            m_age = clampi(m_age + 1, 0, 65535);
            m_live++;
            if (m_hunger >= 12 || m_hygiene >= 12) begin
                m_health = clampi(m_health + 1, 0, 15);
                m_heal_run = 0;
            end else begin
                m_heal_run++;
                if (m_heal_run % HEALP == 0) m_health = clampi(m_health - 1, 0, 15);
            end
            if (m_live % HUNP == 0) m_hunger = clampi(m_hunger + 1, 0, 15);
            if (!was_sleep) begin
                m_awake++;
                m_eticks++;
                if (m_awake % HAPP == 0) m_happy = clampi(m_happy + 1, 0, 31);
                if (m_awake % HYGP == 0) m_hygiene = clampi(m_hygiene + 1, 0, 15);
                if (m_awake % SOCP == 0) m_social = clampi(m_social + 1, 0, 15);
                if (m_eticks % ENGP == 0) m_energy = clampi(m_energy + 1, 0, 15);
            end else begin
                m_energy = clampi(m_energy - 1, 0, 15);
                m_sticks++;
                if (m_energy == 0 || m_sticks == SLPT) begin
                    m_sleep = 0;
                    m_eticks = 0;
                end
            end
        end
        if (m_hunger == 15 || m_health == 15) begin
            m_dead = 1;
            m_sleep = 0;
        end
    endfunction

    function automatic logic [63:0] modelPack();
        return expPack(m_hunger, m_happy, m_health, m_hygiene, m_energy, m_social,
                       int'(m_sleep), int'(m_dead), int'(!m_sleep && !m_dead), m_age);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, actual, expected, edge_no);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c);
        act_valid = v;
        act_code  = c;
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic runTo(input int target);
        while (edge_no < target) applyStimulus(1'b0, 3'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        reset = 1'b0;
        #1;
        edge_no = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        act_valid = 1'b0;
        act_code = 3'd0;

        // Action table, each applied at edge 81 from the state reached after 20 idle ticks.
        vecs[0] = '{3'd0,  6, 6, 0, 5, 4, 6, 0, 1};
        vecs[1] = '{3'd1, 10, 2, 0, 5, 6, 6, 0, 1};
        vecs[2] = '{3'd2, 10, 6, 0, 0, 4, 6, 0, 1};
        vecs[3] = '{3'd3, 10, 6, 0, 5, 4, 6, 1, 0};
        vecs[4] = '{3'd4, 10, 6, 0, 5, 4, 6, 0, 1};
        vecs[5] = '{3'd5, 10, 4, 0, 5, 4, 2, 0, 1};
        vecs[6] = '{3'd6, 10, 6, 0, 5, 4, 6, 0, 1};
        vecs[7] = '{3'd7, 10, 6, 0, 5, 4, 6, 0, 1};

        // Decay to death with no actions.
        doReset();
        checkOutput("reset_state", dutPack(), expPack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        runTo(8);   checkOutput("decay_hunger_c8", 64'(hunger), 64'd1);
        runTo(56);  checkOutput("decay_hunger_c56", 64'(hunger), 64'd7);
        runTo(96);  checkOutput("decay_c96", {hunger, health}, {4'd12, 4'd0});
        runTo(100); checkOutput("decay_health_rise", 64'(health), 64'd1);
        runTo(119); checkOutput("decay_alive_c119", 64'(dead), 64'd0);
        runTo(120); checkOutput("decay_dead_c120", dutPack(), expPack(15, 10, 6, 7, 6, 10, 0, 1, 0, 30));
        runTo(220); checkOutput("dead_frozen", dutPack(), expPack(15, 10, 6, 7, 6, 10, 0, 1, 0, 30));

        reset = 1'b1;
        #1;
        checkOutput("dead_reset_ready_low", 64'(act_ready), 64'd0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("dead_reset_clear", dutPack(), expPack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        #1;
        checkOutput("dead_reset_release_ready", 64'(act_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            doReset();
            runTo(80);
            applyStimulus(1'b1, vecs[i].code);
            checkOutput($sformatf("action_code%0d", vecs[i].code), dutPack(),
                        expPack(vecs[i].hunger, vecs[i].happiness, vecs[i].health, vecs[i].hygiene,
                                vecs[i].energy, vecs[i].social, vecs[i].sleeping, 0, vecs[i].ready, 20));
        end

        // Feed clamping at 0 and feed coinciding with a hunger tick.
        doReset();
        runTo(16); checkOutput("feed_pre2", 64'(hunger), 64'd2);
        applyStimulus(1'b1, 3'd0);
        checkOutput("feed_clamp0", 64'(hunger), 64'd0);
        runTo(95); checkOutput("feed_pre9", 64'(hunger), 64'd9);
        applyStimulus(1'b1, 3'd0);
        checkOutput("feed_on_tick", 64'(hunger), 64'd6);

        // Sleep until energy runs out, with a FEED request held during sleep.
        doReset();
        runTo(20); checkOutput("sleep_energy1", 64'(energy), 64'd1);
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd1);
        checkOutput("sleep_energy5", 64'(energy), 64'd5);
        applyStimulus(1'b1, 3'd3);
        checkOutput("sleep_enter", dutPack(), expPack(2, 0, 0, 1, 5, 1, 1, 0, 0, 5));
        while (edge_no < 39) applyStimulus(1'b1, 3'd0);
        checkOutput("sleep_c39", dutPack(), expPack(4, 0, 0, 1, 1, 1, 1, 0, 0, 9));
        applyStimulus(1'b1, 3'd0);
        checkOutput("sleep_wake_energy0", dutPack(), expPack(5, 0, 0, 1, 0, 1, 0, 0, 1, 10));
        applyStimulus(1'b1, 3'd0);
        checkOutput("feed_after_wake", 64'(hunger), 64'd1);
        act_valid = 1'b0;

        // Sleep capped by the sleep duration limit.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'd1);
        checkOutput("limit_energy15", 64'(energy), 64'd15);
        applyStimulus(1'b1, 3'd3);
        checkOutput("limit_sleeping", {sleeping, act_ready}, {1'b1, 1'b0});
        runTo(39); checkOutput("limit_c39", {sleeping, energy}, {1'b1, 4'd8});
        runTo(40); checkOutput("limit_wake", {sleeping, act_ready, energy}, {1'b1 ^ 1'b1, 1'b1, 4'd7});

        // Reset while sleeping.
        doReset();
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd3);
        runTo(5);
        checkOutput("midsleep_sleeping", 64'(sleeping), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("midsleep_reset_ready_low", 64'(act_ready), 64'd0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("midsleep_reset_clear", dutPack(), expPack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        #1;
        checkOutput("midsleep_release_ready", 64'(act_ready), 64'd1);

        // Randomized episodes with different action densities.
        for (int ep = 0; ep < 4; ep++) begin
            int pct;
            pct = (ep == 0) ? 60 : (ep == 1) ? 25 : (ep == 2) ? 8 : 3;
            doReset();
            modelReset();
            for (int n = 0; n < 1000; n++) begin
                logic        v;
                logic [2:0]  c;
                v = ($urandom_range(0, 99) < pct);
                c = 3'($urandom_range(0, 7));
                modelStep(v, int'(c));
                applyStimulus(v, c);
                checkOutput("random", dutPack(), modelPack());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/needs_engine.md
# needs_engine

Need-level generator for the pet. It advances hunger, happiness, health, hygiene, energy and social on a prescaled game tick and applies player care actions through a valid/ready handshake. It drives the need inputs of the status evaluator, using the same widths and the same "higher is worse" convention. It also owns the pet's life state (alive, sleeping, dead) and an age counter.

## Interface
- TICK_DIV, 50_000_000: clk cycles per game tick (≥2)
- HUNGER_PER, 2: ticks per hunger +1
- HAPPY_PER, 3: ticks per happiness +1
- HYGIENE_PER, 4: ticks per hygiene +1
- ENERGY_PER, 5: ticks per energy +1 (awake only)
- SOCIAL_PER, 3: ticks per social +1
- HEAL_PER, 4: ticks per health −1 when not afflicted
- SLEEP_TICKS, 8: maximum sleep duration in ticks

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- act_valid  in  1  action request
- act_code  in  3  0 FEED, 1 PLAY, 2 CLEAN, 3 SLEEP, 4 MEDICINE, 5 SOCIAL, 6–7 no-op
- act_ready  out  1  action can be accepted
- hunger  out  4  hunger level
- happiness  out  5  unhappiness level
- health  out  4  sickness level
- hygiene  out  4  dirtiness level
- energy  out  4  tiredness level
- social  out  4  loneliness level
- sleeping  out  1  in SLEEPING state
- dead  out  1  in DEAD state
- age  out  16  ticks lived, saturates at 65535

## Operation
- All outputs are registered. Reset values: every need 0, age 0, sleeping 0, dead 0, state ALIVE, prescaler 0, all period counters 0.
- Prescaler: counts 0..TICK_DIV−1. An internal tick pulses for one cycle when the count equals TICK_DIV−1, then the count wraps to 0.
- Per-need period counters advance only on a tick. A need's increment fires on the tick where its counter reaches PER−1; the counter then wraps.
- Saturation: 4-bit needs clamp at 15, happiness clamps at 31, and every need clamps at 0 on decrement.
- Health on each tick: if the pre-tick hunger ≥12 or the pre-tick hygiene ≥12, health +1 and the heal counter is cleared. Otherwise health −1 every HEAL_PER ticks.
- Handshake: act_ready = (state == ALIVE) and not reset. An action is accepted on a cycle where act_valid and act_ready are both high. Exactly one action is applied per accepted cycle.
- Action effects:
  - FEED: hunger −4.
  - PLAY: happiness −4, energy +2.
  - CLEAN: hygiene = 0.
  - SLEEP: enter SLEEPING and clear the sleep counter.
  - MEDICINE: health −6.
  - SOCIAL: social −4, happiness −2.
  - 6–7: accepted with no effect.
- Simultaneous action and tick on the same need: new = clamp_hi(clamp_lo(old − dec) + inc). The action applies first, then the tick.
- States:
  - ALIVE: all rules active.
  - SLEEPING: hunger and health rules are active. Happiness, hygiene and social counters and values are frozen. Energy −1 per tick instead of incrementing. act_ready = 0.
    - Returns to ALIVE on the tick where energy becomes 0 or SLEEP_TICKS ticks have elapsed, whichever comes first.
    - The energy period counter restarts at 0 on wake.
  - DEAD: entered on the edge where hunger or health becomes 15, from either ALIVE or SLEEPING. All outputs freeze, dead = 1, sleeping = 0, act_ready = 0. DEAD is left only by reset.
- Age increments on every tick while ALIVE or SLEEPING.

## Timing
- An action accepted at edge N is visible on the outputs from edge N; act_ready drops in the cycle after a SLEEP is accepted.
- A tick at edge N updates the needs at edge N. The sleeping, dead and act_ready transitions caused by that update are also visible after edge N.
- A death transition and the final need value appear on the same edge.
- Reset asserted mid-sleep or while DEAD returns every output to its reset value at the next edge. act_ready is 0 while reset is high and 1 in the first cycle after it is released.

## Test plan
- Decay to death: TICK_DIV=4, defaults, no actions. hunger=1 at cycle 8, hunger=7 at cycle 56, hunger=12 at cycle 96, and health starts rising on the next tick. hunger=15 with dead=1 at cycle 120; outputs then stay constant for 100 more cycles.
- Feed and clamp: hunger=2, FEED accepted → hunger=0. hunger=9, FEED accepted on a hunger tick edge → hunger=6.
- Sleep:
  - energy=5, SLEEP accepted → sleeping=1, act_ready=0.
  - energy reaches 0 after 5 ticks → sleeping=0 and act_ready=1 on that edge.
  - hygiene and social are unchanged across the sleep.
- Sleep limit: energy=15, SLEEP accepted, SLEEP_TICKS=8 → wake after 8 ticks with energy=7.
- Handshake: act_valid held high while SLEEPING → no action applied; the action is accepted on the first cycle after wake. Code 7 is accepted with all needs unchanged.
- Reset mid-operation: reset asserted while DEAD or SLEEPING → the next edge gives all needs 0, age 0, dead 0, sleeping 0. act_ready=1 in the cycle after reset is released.
